count_sequence_checker: RTL
===========================

Name: count_sequence_checker

Overview:
- Receive-side monitor for the 4-bit up/down ripple counter.
- Samples the counter's Q bus together with the counter's enable and direction controls. Checks that every sampled value is the legal successor of the previous one, with wrap-around.
- Reports lock status, single-cycle error and wrap pulses, and a saturating error count.
- Sits beside the counter in the bench and on-chip debug path as the consumer of its output.

Parameters:
- WIDTH, 4, width of the counter value being checked.
- LOCK_N, 4, consecutive correct steps required to declare lock (min 1).
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- valid  input  1  q_in/en/dir are sampled this cycle.
- en  input  1  counter enable (T); 1 = counter should step, 0 = counter should hold.
- dir  input  1  counter direction (C); 1 = up, 0 = down.
- q_in  input  WIDTH  observed counter value.
- clr_err  input  1  clears err_count.
- locked  output  1  checker is in TRACK state.
- err_pulse  output  1  one-cycle pulse per detected mismatch while locked.
- wrap_pulse  output  1  one-cycle pulse per matched wrap step.
- err_count  output  CNT_W  saturating count of errors.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, ref=0, good_cnt=0, locked=0, err_pulse=0, wrap_pulse=0, err_count=0.
- Reset wins over every other input. Reset asserted mid-operation returns all registers to reset values at that edge.
- All outputs are registered. Pulses appear the cycle after the sample that caused them and last exactly 1 cycle.
- Expected value: exp = en ? (dir ? ref+1 : ref-1) mod 2^WIDTH : ref.
  - en and dir are taken from the same cycle as q_in.
- valid=0: no state change; err_pulse=0, wrap_pulse=0; err_count changes only via clr_err.
- IDLE state: on valid, ref<=q_in, good_cnt<=0, go to ACQ.
- ACQ state: on valid, compare q_in with exp.
  - Match: ref<=q_in, good_cnt<=good_cnt+1. When the incremented count equals LOCK_N, go to TRACK and set locked=1.
  - Mismatch: ref<=q_in (resync), good_cnt<=0, stay in ACQ. No error is counted.
- TRACK state: on valid, compare q_in with exp.
  - Match: ref<=q_in.
  - Mismatch: err_pulse=1, err_count saturating +1, ref<=q_in, good_cnt<=0, locked=0, go to ACQ.
- wrap_pulse: asserted on any matched step with en=1 in ACQ or TRACK that crosses the boundary.
  - Up: ref=2^WIDTH-1 and q_in=0.
  - Down: ref=0 and q_in=2^WIDTH-1.
- err_count saturates at 2^CNT_W-1 and never wraps.
- clr_err and an error in the same cycle: err_count becomes 1 (clear applied first, then the new error counted).
- clr_err alone: err_count becomes 0 next cycle. State is unaffected.
- A direction change is legal at any sample. The step is checked against the dir value presented with that sample.

Test Plan:
- Up lock and wrap: WIDTH=4, LOCK_N=4, en=1, dir=1, valid=1, q_in=0,1,…,15,0,1 → locked rises the cycle after q_in=4. wrap_pulse is high for exactly one cycle, the cycle after q_in=0 follows 15. err_count=0.
- Down: dir=0, q_in=3,2,1,0,15,14 → locked rises the cycle after q_in=15. wrap_pulse is high in that same cycle. No errors.
- Hold: after lock, en=0, q_in=7 repeated 5 times → locked stays 1, no pulses. Then en=1 with q_in=7 → err_pulse=1, err_count=1, locked=0.
- Error and relock: locked in up mode, q_in=5 then 9 → err_pulse one cycle, err_count=1, locked=0. Then q_in=10,11,12,13 → locked=1 again the cycle after 13.
- Saturation and clear: CNT_W=2, force 5 errors (relocking between them) → err_count=3 and holds. clr_err together with a 6th error → err_count=1. clr_err alone → 0.
- Reset mid-track and valid gaps: reset=1 for one cycle while locked → next cycle locked=0, err_count=0, state IDLE. Toggling valid=0 between good samples neither breaks lock nor generates pulses.

Source files
------------

// File: rtl/count_sequence_checker.sv
// count_sequence_checker: receive-side monitor for a WIDTH-bit up/down
// counter. Tracks the previous sampled value, predicts the next one from
// en/dir, and reports lock, error/wrap pulses and a saturating error count.
module count_sequence_checker #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned LOCK_N = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic             en,
    input  logic             dir,
    input  logic [WIDTH-1:0] q_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned GW = $clog2(LOCK_N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   ref_q, ref_d;
    logic [GW-1:0]      good_q, good_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic               wrap_pulse_q, wrap_pulse_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0]   exp_val;
    logic               match;
    logic [GW-1:0]      good_inc;
    logic [CNT_W-1:0]   cnt_base;

    // State register: all checker state, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ref_q        <= '0;
            good_q       <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            ref_q        <= ref_d;
            good_q       <= good_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            wrap_pulse_q <= wrap_pulse_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // Next-state logic: predict successor, acquire/track/resync
    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        good_d   = good_q;
        exp_val  = ref_q;
        if (en) begin
            exp_val = dir ? (ref_q + 1'b1) : (ref_q - 1'b1);
        end
        match    = (q_in == exp_val);
        good_inc = good_q + 1'b1;
        if (valid) begin
            case (state_q)
                IDLE: begin
                    ref_d   = q_in;
                    good_d  = '0;
                    state_d = ACQ;
                end
                ACQ: begin
                    ref_d = q_in;
                    if (match) begin
                        good_d = good_inc;
                        if (good_inc == GW'(LOCK_N)) begin
                            state_d = TRACK;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                TRACK: begin
                    ref_d = q_in;
                    if (!match) begin
                        good_d  = '0;
                        state_d = ACQ;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output logic: pulses and error count; a clear is applied before the new error
    always_comb begin
        locked_d    = (state_d == TRACK);
        err_pulse_d = valid && (state_q == TRACK) && !match;
        wrap_pulse_d = valid && (state_q != IDLE) && match && en &&
                       (dir ? ((ref_q == '1) && (q_in == '0))
                            : ((ref_q == '0) && (q_in == '1)));
        cnt_base  = clr_err ? '0 : err_cnt_q;
        err_cnt_d = cnt_base;
        if (err_pulse_d && (cnt_base != '1)) begin
            err_cnt_d = cnt_base + 1'b1;
        end
    end

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign wrap_pulse = wrap_pulse_q;
    assign err_count  = err_cnt_q;

endmodule
